prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Boot/program loader that sequences the otherwise-unused instr_mem write port (wdata/we).
//  Holds the CPU core in reset, streams instruction words over a valid/ready port into
//  consecutive program-memory addresses from 0, then releases CPU reset after a settle delay.
//  Sits beside cpu: mem_* drive instr_mem write side, cpu_rst drives program_counter/decode/alu/reg_file rst.
// PARAMETERS
//  PIC_INSTR_WIDTH          12  instruction word width
//  L2_PIC_INSTR_MEM_DEPTH   9   log2 program memory depth (DEPTH = 2**L2)
//  RELEASE_CYCLES           4   cycles cpu_rst held after load completes (one q1..q4 instr cycle); >=1
// PORTS
//  clk        in   1                       system clock
//  rst        in   1                       synchronous active-high reset
//  load_req   in   1                       pulse/level: start (re)load
//  run_req    in   1                       pulse/level: release CPU without loading
//  s_valid    in   1                       instruction word valid
//  s_ready    out  1                       loader accepts word this cycle
//  s_data     in   PIC_INSTR_WIDTH         instruction word
//  s_last     in   1                       marks final word of image
//  mem_addr   out  L2_PIC_INSTR_MEM_DEPTH  instr_mem write address
//  mem_wdata  out  PIC_INSTR_WIDTH         instr_mem write data
//  mem_we     out  1                       instr_mem write enable
//  cpu_rst    out  1                       reset to CPU core, active-high
//  busy       out  1                       state is LOAD or RELEASE
//  overflow   out  1                       sticky: image exceeded DEPTH words without s_last
//  word_count out  L2_PIC_INSTR_MEM_DEPTH+1  words written in current/last load
// BEHAVIOUR
//  All outputs registered. Reset values: state IDLE, s_ready=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, cpu_rst=1, busy=0, overflow=0, word_count=0, release counter=0.
//  States: IDLE, LOAD, RELEASE, RUN, ERR.
//  IDLE: cpu_rst=1. load_req -> LOAD (priority over run_req); else run_req -> RELEASE.
//  LOAD: s_ready=1; cpu_rst=1. Entry clears word_count, write pointer=0, overflow=0.
//   Accept = s_valid & s_ready. Accept at cycle N -> cycle N+1: mem_we=1, mem_addr=ptr,
//   mem_wdata=s_data; ptr and word_count +1. No accept -> mem_we=0 next cycle.
//   Accept with s_last -> RELEASE; s_ready=0 from next cycle.
//   Accept at ptr==DEPTH-1 without s_last -> ERR, overflow=1 (last word still written);
//   s_last at ptr==DEPTH-1 -> RELEASE, no overflow. ptr never wraps.
//   load_req/run_req ignored in LOAD.
//  RELEASE: s_ready=0, cpu_rst=1, counter counts RELEASE_CYCLES cycles; entering at cycle T,
//   cpu_rst=0 first visible at T+RELEASE_CYCLES (state RUN). Pending mem_we of final word
//   completes in first RELEASE cycle. load_req in RELEASE -> LOAD, counter cleared.
//  RUN: cpu_rst=0, busy=0. load_req -> LOAD; cpu_rst=1 visible next cycle. run_req ignored.
//  ERR: cpu_rst=1, s_ready=0, overflow held. load_req -> LOAD; run_req ignored.
//  rst mid-load: immediate return to reset values; partially written memory untouched.
//  mem_we is never asserted outside the cycle after an accept.
//  word_count saturates at DEPTH; holds value after load until next LOAD entry.
// TESTING
//  T1 rst, load_req, 3 words 0xA01,0x025,0xC05 (last on 3rd) -> mem_we at addr 0,1,2 with
//     those data, word_count=3, cpu_rst low exactly 4 cycles after RELEASE entry.
//  T2 s_valid toggled 1/0 every other cycle -> writes only on accept cycles, addresses
//     contiguous 0..N-1, no gaps, no duplicates.
//  T3 stream 512 words, no s_last -> addr 511 written, overflow=1, state ERR, cpu_rst=1;
//     then load_req -> overflow cleared, new load from addr 0.
//  T4 512 words with s_last on word 512 -> overflow=0, RELEASE then RUN.
//  T5 RUN, pulse load_req -> cpu_rst=1 next cycle, s_ready=1, reload from addr 0;
//     run_req from IDLE -> no mem_we, cpu_rst low after 4 cycles.
//  T6 rst asserted after 2 of 5 words -> all outputs at reset values next cycle, load_req
//     and run_req together in IDLE -> LOAD chosen.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: holds the CPU in reset, streams an instruction image into
// instr_mem from address 0, then releases CPU reset after a settle delay.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_req          start (re)load; wins over run_req
//   run_req           release CPU without loading
//   s_valid/s_ready   instruction word handshake
//   s_data/s_last     instruction word, final-word marker
//   mem_addr/wdata/we instr_mem write side
//   cpu_rst           active-high reset to the CPU core
//   busy              loading or releasing
//   overflow          sticky: image ran past DEPTH words without s_last
//   word_count        words written in current/last load (saturating)
module prog_loader #(
  parameter int PIC_INSTR_WIDTH        = 12,
  parameter int L2_PIC_INSTR_MEM_DEPTH = 9,
  parameter int RELEASE_CYCLES         = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_req,
  input  logic                              run_req,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [PIC_INSTR_WIDTH-1:0]        s_data,
  input  logic                              s_last,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] mem_addr,
  output logic [PIC_INSTR_WIDTH-1:0]        mem_wdata,
  output logic                              mem_we,
  output logic                              cpu_rst,
  output logic                              busy,
  output logic                              overflow,
  output logic [L2_PIC_INSTR_MEM_DEPTH:0]   word_count
);

  localparam int AW    = L2_PIC_INSTR_MEM_DEPTH;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(RELEASE_CYCLES + 1);

  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [AW:0]   WC_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN,
    ERR
  } state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [CW-1:0]   rel_cnt;
  logic            accept;
  logic            go_load;

  assign accept  = s_valid & s_ready;
  // load_req restarts from every state except LOAD itself
  assign go_load = load_req & (state != LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      ptr        <= '0;
      rel_cnt    <= '0;
    end else begin
      mem_we <= 1'b0;
      if (go_load) begin
        state      <= LOAD;
        s_ready    <= 1'b1;
        cpu_rst    <= 1'b1;
        busy       <= 1'b1;
        overflow   <= 1'b0;
        word_count <= '0;
        ptr        <= '0;
        rel_cnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (run_req) begin
              state   <= RELEASE;
              busy    <= 1'b1;
              rel_cnt <= '0;
            end
          end
          LOAD: begin
            if (accept) begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= s_data;
              if (word_count != WC_MAX)
                word_count <= word_count + 1'b1;
              if (s_last) begin
                state   <= RELEASE;
                s_ready <= 1'b0;
                rel_cnt <= '0;
              end else if (ptr == PTR_MAX) begin
                // last slot filled with no s_last: stop, never wrap
                state    <= ERR;
                s_ready  <= 1'b0;
                busy     <= 1'b0;
                overflow <= 1'b1;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end
          end
          RELEASE: begin
            if (rel_cnt == REL_LAST) begin
              state   <= RUN;
              cpu_rst <= 1'b0;
              busy    <= 1'b0;
            end else begin
              rel_cnt <= rel_cnt + 1'b1;
            end
          end
          RUN: begin
          end
          ERR: begin
          end
          default: begin
            state   <= IDLE;
            s_ready <= 1'b0;
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus random traffic,
// checked each cycle against a phase-level reference model.
module tb_prog_loader;

  localparam int W     = 12;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int RC    = 4;

  logic          clk;
  logic          rst;
  logic          load_req;
  logic          run_req;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_we;
  logic          cpu_rst;
  logic          busy;
  logic          overflow;
  logic [AW:0]   word_count;

  prog_loader #(
    .PIC_INSTR_WIDTH(W),
    .L2_PIC_INSTR_MEM_DEPTH(AW),
    .RELEASE_CYCLES(RC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_req(load_req),
    .run_req(run_req),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .overflow(overflow),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Observed memory image, filled from the write port
  logic [W-1:0] tmem [DEPTH];
  logic [W-1:0] img  [DEPTH];

  always @(negedge clk)
    if (mem_we) tmem[mem_addr] <= mem_wdata;

  // Reference model: phase names follow the loader's behaviour,
  // release delay modelled as a countdown of remaining cycles.
  localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3, P_ERR = 4;
  int          ph;
  int          left;
  int          wp;
  int          m_wc;
  bit          m_ovf;
  bit          m_we;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;

  task automatic model_step(input logic v, input logic [W-1:0] d,
                            input logic l, input logic lr,
                            input logic rr, input logic r);
    if (r) begin
      ph = P_IDLE; m_we = 0; m_addr = '0; m_data = '0;
      m_ovf = 0; m_wc = 0; wp = 0;
      return;
    end
    m_we = 0;
    if (lr && ph != P_LOAD) begin
      ph = P_LOAD; wp = 0; m_wc = 0; m_ovf = 0;
      return;
    end
    case (ph)
      P_IDLE: if (rr) begin ph = P_REL; left = RC; end
      P_LOAD: if (v) begin
        m_we = 1; m_addr = AW'(wp); m_data = d;
        if (m_wc < DEPTH) m_wc++;
        if (l) begin ph = P_REL; left = RC; end
        else if (wp == DEPTH - 1) begin ph = P_ERR; m_ovf = 1; end
        else wp++;
      end
      P_REL: begin
        left--;
        if (left == 0) ph = P_RUN;
      end
      default: ;
    endcase
  endtask

  task automatic compare();
    check("s_ready", s_ready, 32'(ph == P_LOAD));
    check("cpu_rst", cpu_rst, 32'(ph != P_RUN));
    check("busy", busy, 32'(ph == P_LOAD || ph == P_REL));
    check("mem_we", mem_we, 32'(m_we));
    check("mem_addr", mem_addr, 32'(m_addr));
    check("mem_wdata", mem_wdata, 32'(m_data));
    check("overflow", overflow, 32'(m_ovf));
    check("word_count", word_count, 32'(m_wc));
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic l,
                     input logic lr, input logic rr, input logic r);
    rst = r; s_valid = v; s_data = d; s_last = l;
    load_req = lr; run_req = rr;
    @(posedge clk);
    model_step(v, d, l, lr, rr, r);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0, 0);
  endtask

  // Pulse load_req, then stream n words of img (optionally with
  // one bubble before every odd word).
  task automatic load(input int n, input bit with_last, input bit gaps);
    cyc(0, '0, 0, 1, 0, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps && i[0]) cyc(0, W'($urandom), 1, 0, 0, 0);
      cyc(1, img[i], with_last && (i == n - 1), 0, 0, 0);
    end
  endtask

  task automatic check_mem(input string tag, input int n);
    for (int i = 0; i < n; i++) check(tag, tmem[i], img[i]);
  endtask

  int rel_seen;

  initial begin
    ph = P_IDLE; left = 0; wp = 0; m_wc = 0; m_ovf = 0;
    m_we = 0; m_addr = '0; m_data = '0;
    rst = 1; load_req = 0; run_req = 0;
    s_valid = 0; s_data = '0; s_last = 0;
    for (int i = 0; i < DEPTH; i++) tmem[i] = '0;

    // reset state
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 1);
    idle(2);

    // T1: three-word image, release delay measured explicitly
    img[0] = 12'hA01; img[1] = 12'h025; img[2] = 12'hC05;
    load(3, 1, 0);
    rel_seen = 0;
    while (cpu_rst && rel_seen < 20) begin
      idle(1);
      rel_seen++;
    end
    check("t1_release_delay", rel_seen, RC);
    check_mem("t1_mem", 3);
    check("t1_wc", word_count, 3);

    // T2: bubbles between words
    for (int i = 0; i < 9; i++) img[i] = W'($urandom);
    load(9, 1, 1);
    idle(6);
    check_mem("t2_mem", 9);

    // T3: overflow, then reload
    for (int i = 0; i < DEPTH; i++) img[i] = W'($urandom);
    load(DEPTH, 0, 0);
    idle(3);
    check("t3_ovf", overflow, 1);
    check_mem("t3_mem", DEPTH);
    for (int i = 0; i < 2; i++) img[i] = W'($urandom);
    load(2, 1, 0);
    check("t3_ovf_clr", overflow, 0);
    idle(6);
    check_mem("t3_reload", 2);

    // T4: exactly DEPTH words, last on final slot
    for (int i = 0; i < DEPTH; i++) img[i] = W'($urandom);
    load(DEPTH, 1, 0);
    idle(6);
    check("t4_wc", word_count, DEPTH);
    check_mem("t4_mem", DEPTH);

    // T5: reload from RUN, then run_req from IDLE
    for (int i = 0; i < 4; i++) img[i] = W'($urandom);
    load(4, 1, 0);
    idle(6);
    check_mem("t5_mem", 4);
    cyc(0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1, 0);
    idle(6);

    // T6: reset mid-load, then load_req and run_req together
    for (int i = 0; i < 5; i++) img[i] = W'($urandom);
    cyc(0, '0, 0, 1, 0, 0);
    cyc(1, img[0], 0, 0, 0, 0);
    cyc(1, img[1], 0, 0, 0, 0);
    cyc(1, img[2], 0, 0, 0, 1);
    cyc(0, '0, 0, 1, 1, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(1, 0), W'($urandom), $urandom_range(7, 0) == 0,
          $urandom_range(29, 0) == 0, $urandom_range(19, 0) == 0,
          $urandom_range(199, 0) == 0);
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
